// File: rtl/ex_stage_md.sv
// EX stage with forwarding, ALU, JAL link path and a registered EX/MEM boundary.
// Also holds an iterative one-bit-per-cycle multiply/divide unit with HI/LO registers.
module ex_stage_md #(
   parameter int NB_REG   = 32,
   parameter int NB_ADDR  = 5,
   parameter int ALU_OP   = 4,
   parameter int NB_MD_OP = 3
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic                        i_alu_src_CU,
   input  logic                        i_reg_dst_CU,
   input  logic                        i_jal_sel_CU,
   input  logic [ALU_OP-1:0]           i_alu_op_CU,
   input  logic [NB_MD_OP-1:0]         i_md_op_CU,
   input  logic [NB_REG-1:0]           i_rs_data,
   input  logic [NB_REG-1:0]           i_rt_data,
   input  logic [NB_REG-1:0]           i_inst_sign_extended,
   input  logic [$clog2(NB_REG)-1:0]   i_shamt,
   input  logic [NB_REG-1:0]           i_pc_plus8,
   input  logic [NB_ADDR-1:0]          i_rd_from_ID,
   input  logic [NB_ADDR-1:0]          i_rt_from_ID,
   input  logic [NB_REG-1:0]           i_aluResult_MEM,
   input  logic [NB_REG-1:0]           i_aluResult_WB,
   input  logic [1:0]                  i_forwardA,
   input  logic [1:0]                  i_forwardB,
   output logic [NB_REG-1:0]           o_alu_result,
   output logic [NB_ADDR-1:0]          o_write_reg,
   output logic [NB_REG-1:0]           o_store_data,
   output logic                        o_alu_condition_zero,
   output logic                        o_valid,
   output logic                        o_stall,
   output logic                        o_md_busy
);
   // state   | meaning
   // MD_IDLE | no iteration; HI/LO readable, new MD op may start
   // MD_RUN  | iterating one bit per cycle; counter counts down to 0

   localparam int NB_CNT = $clog2(NB_REG + 1);

   localparam logic [ALU_OP-1:0] OP_ADD  = ALU_OP'(0);
   localparam logic [ALU_OP-1:0] OP_SUB  = ALU_OP'(1);
   localparam logic [ALU_OP-1:0] OP_AND  = ALU_OP'(2);
   localparam logic [ALU_OP-1:0] OP_OR   = ALU_OP'(3);
   localparam logic [ALU_OP-1:0] OP_XOR  = ALU_OP'(4);
   localparam logic [ALU_OP-1:0] OP_NOR  = ALU_OP'(5);
   localparam logic [ALU_OP-1:0] OP_SLT  = ALU_OP'(6);
   localparam logic [ALU_OP-1:0] OP_SLTU = ALU_OP'(7);
   localparam logic [ALU_OP-1:0] OP_SLL  = ALU_OP'(8);
   localparam logic [ALU_OP-1:0] OP_SRL  = ALU_OP'(9);
   localparam logic [ALU_OP-1:0] OP_SRA  = ALU_OP'(10);
   localparam logic [ALU_OP-1:0] OP_LUI  = ALU_OP'(11);

   localparam logic [NB_MD_OP-1:0] MD_MULT  = NB_MD_OP'(1);
   localparam logic [NB_MD_OP-1:0] MD_MULTU = NB_MD_OP'(2);
   localparam logic [NB_MD_OP-1:0] MD_DIV   = NB_MD_OP'(3);
   localparam logic [NB_MD_OP-1:0] MD_DIVU  = NB_MD_OP'(4);
   localparam logic [NB_MD_OP-1:0] MD_MFHI  = NB_MD_OP'(5);
   localparam logic [NB_MD_OP-1:0] MD_MFLO  = NB_MD_OP'(6);

   typedef enum logic {MD_IDLE, MD_RUN} md_state_t;
   md_state_t state_q, state_d;

   logic [NB_REG-1:0]   opa, opb_reg, opb, alu_out, res_sel;
   logic [NB_ADDR-1:0]  dst;
   logic                md_req, md_start_op, md_signed, accept, md_start, md_last;
   logic [NB_REG-1:0]   a_mag, b_mag;

   logic [NB_REG-1:0]   md_hi, md_lo, md_den, md_a;
   logic                md_is_div, md_neg_q, md_neg_r, md_div0;
   logic [NB_CNT-1:0]   md_cnt;
   logic [NB_REG-1:0]   hi_q, lo_q;

   logic [NB_REG:0]     mul_sum, div_shift, div_diff;
   logic [NB_REG-1:0]   hi_step, lo_step, quo_fix, rem_fix;
   logic [2*NB_REG-1:0] prod_fix;

   always_comb begin
      case (i_forwardA)
         2'b01:   opa = i_aluResult_MEM;
         2'b10:   opa = i_aluResult_WB;
         default: opa = i_rs_data;
      endcase
      case (i_forwardB)
         2'b01:   opb_reg = i_aluResult_MEM;
         2'b10:   opb_reg = i_aluResult_WB;
         default: opb_reg = i_rt_data;
      endcase
      opb = i_alu_src_CU ? i_inst_sign_extended : opb_reg;
   end

   always_comb begin
      case (i_alu_op_CU)
         OP_ADD:  alu_out = opa + opb;
         OP_SUB:  alu_out = opa - opb;
         OP_AND:  alu_out = opa & opb;
         OP_OR:   alu_out = opa | opb;
         OP_XOR:  alu_out = opa ^ opb;
         OP_NOR:  alu_out = ~(opa | opb);
         OP_SLT:  alu_out = {{(NB_REG-1){1'b0}}, ($signed(opa) < $signed(opb))};
         OP_SLTU: alu_out = {{(NB_REG-1){1'b0}}, (opa < opb)};
         OP_SLL:  alu_out = opb << i_shamt;
         OP_SRL:  alu_out = opb >> i_shamt;
         OP_SRA:  alu_out = $unsigned($signed(opb) >>> i_shamt);
         OP_LUI:  alu_out = i_inst_sign_extended << 16;
         default: alu_out = '0;
      endcase
   end

   // Opcode 7 falls outside both ranges and so behaves as "no MD op".
   assign md_req      = (i_md_op_CU >= MD_MULT) && (i_md_op_CU <= MD_MFLO);
   assign md_start_op = (i_md_op_CU >= MD_MULT) && (i_md_op_CU <= MD_DIVU);
   assign md_signed   = (i_md_op_CU == MD_MULT) || (i_md_op_CU == MD_DIV);
   assign o_md_busy   = (state_q == MD_RUN);
   assign o_stall     = i_valid & md_req & o_md_busy;
   assign accept      = i_valid & ~o_stall;
   assign md_start    = accept & md_start_op;

   assign dst = i_jal_sel_CU ? {NB_ADDR{1'b1}} : (i_reg_dst_CU ? i_rd_from_ID : i_rt_from_ID);

   always_comb begin
      res_sel = '0;
      if (accept && !md_start_op) begin
         if (i_jal_sel_CU)                res_sel = i_pc_plus8;
         else if (i_md_op_CU == MD_MFHI)  res_sel = hi_q;
         else if (i_md_op_CU == MD_MFLO)  res_sel = lo_q;
         else                             res_sel = alu_out;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_alu_result         <= '0;
         o_write_reg          <= '0;
         o_store_data         <= '0;
         o_alu_condition_zero <= 1'b0;
         o_valid              <= 1'b0;
      end else begin
         o_alu_result         <= res_sel;
         o_write_reg          <= (accept && !md_start_op) ? dst : '0;
         o_store_data         <= opb_reg;
         o_alu_condition_zero <= (res_sel == '0);
         o_valid              <= accept;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= MD_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      md_last = 1'b0;
      case (state_q)
         MD_IDLE: if (md_start) state_d = MD_RUN;
         MD_RUN: begin
            if (md_cnt == NB_CNT'(1)) begin
               md_last = 1'b1;
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   assign a_mag = (md_signed && opa[NB_REG-1])     ? -opa     : opa;
   assign b_mag = (md_signed && opb_reg[NB_REG-1]) ? -opb_reg : opb_reg;

   // md_hi/md_lo double as {accumulator, multiplier} or {remainder, quotient}.
   always_comb begin
      mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_den} : '0);
      div_shift = {md_hi, md_lo[NB_REG-1]};
      div_diff  = div_shift - {1'b0, md_den};
      if (md_is_div) begin
         if (div_shift >= {1'b0, md_den}) begin
            hi_step = div_diff[NB_REG-1:0];
            lo_step = {md_lo[NB_REG-2:0], 1'b1};
         end else begin
            hi_step = div_shift[NB_REG-1:0];
            lo_step = {md_lo[NB_REG-2:0], 1'b0};
         end
      end else begin
         hi_step = mul_sum[NB_REG:1];
         lo_step = {mul_sum[0], md_lo[NB_REG-1:1]};
      end
      prod_fix = md_neg_q ? -{hi_step, lo_step} : {hi_step, lo_step};
      quo_fix  = md_neg_q ? -lo_step : lo_step;
      rem_fix  = md_neg_r ? -hi_step : hi_step;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         md_hi     <= '0;
         md_lo     <= '0;
         md_den    <= '0;
         md_a      <= '0;
         md_is_div <= 1'b0;
         md_neg_q  <= 1'b0;
         md_neg_r  <= 1'b0;
         md_div0   <= 1'b0;
         md_cnt    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (md_start) begin
         md_hi     <= '0;
         md_lo     <= a_mag;
         md_den    <= b_mag;
         md_a      <= opa;
         md_is_div <= (i_md_op_CU == MD_DIV) || (i_md_op_CU == MD_DIVU);
         md_neg_q  <= md_signed & (opa[NB_REG-1] ^ opb_reg[NB_REG-1]);
         md_neg_r  <= md_signed & opa[NB_REG-1];
         md_div0   <= (opb_reg == '0);
         md_cnt    <= NB_CNT'(NB_REG);
      end else if (o_md_busy) begin
         md_hi  <= hi_step;
         md_lo  <= lo_step;
         md_cnt <= md_cnt - 1'b1;
         if (md_last) begin
            if (!md_is_div) begin
               hi_q <= prod_fix[2*NB_REG-1:NB_REG];
               lo_q <= prod_fix[NB_REG-1:0];
            end else if (md_div0) begin
               hi_q <= md_a;
               lo_q <= '1;
            end else begin
               hi_q <= rem_fix;
               lo_q <= quo_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed plus randomized bench for ex_stage_md, checked against an arithmetic
// reference model of the ALU and of MULT/DIV results.
module tb_ex_stage_md;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid, i_alu_src_CU, i_reg_dst_CU, i_jal_sel_CU;
   logic [3:0]  i_alu_op_CU;
   logic [2:0]  i_md_op_CU;
   logic [31:0] i_rs_data, i_rt_data, i_inst_sign_extended, i_pc_plus8;
   logic [4:0]  i_shamt, i_rd_from_ID, i_rt_from_ID;
   logic [31:0] i_aluResult_MEM, i_aluResult_WB;
   logic [1:0]  i_forwardA, i_forwardB;
   logic [31:0] o_alu_result, o_store_data;
   logic [4:0]  o_write_reg;
   logic        o_alu_condition_zero, o_valid, o_stall, o_md_busy;

   int passed = 0;
   int total  = 0;

   ex_stage_md dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
      .i_alu_src_CU(i_alu_src_CU), .i_reg_dst_CU(i_reg_dst_CU), .i_jal_sel_CU(i_jal_sel_CU),
      .i_alu_op_CU(i_alu_op_CU), .i_md_op_CU(i_md_op_CU),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
      .i_inst_sign_extended(i_inst_sign_extended), .i_shamt(i_shamt),
      .i_pc_plus8(i_pc_plus8), .i_rd_from_ID(i_rd_from_ID), .i_rt_from_ID(i_rt_from_ID),
      .i_aluResult_MEM(i_aluResult_MEM), .i_aluResult_WB(i_aluResult_WB),
      .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
      .o_alu_result(o_alu_result), .o_write_reg(o_write_reg), .o_store_data(o_store_data),
      .o_alu_condition_zero(o_alu_condition_zero), .o_valid(o_valid),
      .o_stall(o_stall), .o_md_busy(o_md_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_valid = 0; i_alu_src_CU = 0; i_reg_dst_CU = 0; i_jal_sel_CU = 0;
      i_alu_op_CU = 0; i_md_op_CU = 0; i_rs_data = 0; i_rt_data = 0;
      i_inst_sign_extended = 0; i_shamt = 0; i_pc_plus8 = 0;
      i_rd_from_ID = 0; i_rt_from_ID = 0; i_aluResult_MEM = 0; i_aluResult_WB = 0;
      i_forwardA = 0; i_forwardB = 0;
   endtask

   function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r, m, w);
      return (sel == 2'd1) ? m : (sel == 2'd2) ? w : r;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b, imm,
                                           input logic [4:0] sh);
      int sa = a;
      int sb = b;
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return ~(a | b);
         6: return (sa < sb) ? 32'd1 : 32'd0;
         7: return (a < b) ? 32'd1 : 32'd0;
         8: return b << sh;
         9: return b >> sh;
         10: return sb >>> sh;
         11: return imm << 16;
         default: return 32'd0;
      endcase
   endfunction

   task automatic md_ref(input logic [2:0] op, input logic [31:0] a, b,
                         output logic [31:0] hi, output logic [31:0] lo);
      int ia = a;
      int ib = b;
      int unsigned ua = a;
      int unsigned ub = b;
      longint la = ia;
      longint lb = ib;
      longint unsigned lua = ua;
      longint unsigned lub = ub;
      longint p;
      longint unsigned pu;
      hi = 0; lo = 0;
      case (op)
         1: begin p = la * lb; hi = p[63:32]; lo = p[31:0]; end
         2: begin pu = lua * lub; hi = pu[63:32]; lo = pu[31:0]; end
         3: begin
            if (ib == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
            else if (ia == 32'sh8000_0000 && ib == -1) begin lo = 32'h8000_0000; hi = 0; end
            else begin lo = ia / ib; hi = ia % ib; end
         end
         4: begin
            if (ub == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
            else begin lo = ua / ub; hi = ua % ub; end
         end
         default: ;
      endcase
   endtask

   task automatic md_issue(input logic [2:0] op, input logic [31:0] a, b);
      idle();
      i_valid = 1; i_md_op_CU = op; i_rs_data = a; i_rt_data = b;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (o_md_busy && n < 100) begin n++; step(); end
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (o_stall && n < 100) begin n++; step(); end
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi, lo);
      idle();
      i_valid = 1; i_md_op_CU = 3'd6; i_reg_dst_CU = 1; i_rd_from_ID = 5'd7;
      #1 chk({tag, "_mflo_stall"}, {31'd0, o_stall}, 32'd0);
      step();
      chk({tag, "_lo"}, o_alu_result, lo);
      chk({tag, "_mflo_dst"}, {27'd0, o_write_reg}, 32'd7);
      i_md_op_CU = 3'd5;
      step();
      chk({tag, "_hi"}, o_alu_result, hi);
      idle();
   endtask

   task automatic md_check(input string tag, input logic [2:0] op, input logic [31:0] a, b);
      logic [31:0] hi, lo;
      int n;
      md_ref(op, a, b, hi, lo);
      md_issue(op, a, b);
      step();
      chk({tag, "_start_busy"}, {31'd0, o_md_busy}, 32'd1);
      chk({tag, "_start_valid"}, {31'd0, o_valid}, 32'd1);
      chk({tag, "_start_res"}, o_alu_result, 32'd0);
      chk({tag, "_start_dst"}, {27'd0, o_write_reg}, 32'd0);
      idle();
      wait_busy(n);
      chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
      read_hilo(tag, hi, lo);
   endtask

   initial begin
      logic [31:0] a, breg, b, exp_res, hi, lo;
      logic [4:0]  exp_dst;
      logic [2:0]  op;
      int n;

      idle();
      i_rst_n = 0;
      #12;
      chk("rst_result", o_alu_result, 32'd0);
      chk("rst_write_reg", {27'd0, o_write_reg}, 32'd0);
      chk("rst_store", o_store_data, 32'd0);
      chk("rst_flags", {28'd0, o_alu_condition_zero, o_valid, o_stall, o_md_busy}, 32'd0);
      i_rst_n = 1;
      step();

      i_valid = 1; i_alu_op_CU = 0; i_rs_data = 32'h10; i_rt_data = 32'h20;
      i_forwardA = 2'b01; i_aluResult_MEM = 32'h30; i_reg_dst_CU = 1; i_rd_from_ID = 5'd1;
      step();
      chk("add_res", o_alu_result, 32'h50);
      chk("add_dst", {27'd0, o_write_reg}, 32'd1);
      chk("add_zero", {31'd0, o_alu_condition_zero}, 32'd0);

      idle(); i_valid = 1; i_jal_sel_CU = 1; i_pc_plus8 = 32'h108; i_alu_op_CU = 1;
      i_rs_data = 32'h5; i_rt_from_ID = 5'd3;
      step();
      chk("jal_dst", {27'd0, o_write_reg}, 32'd31);
      chk("jal_res", o_alu_result, 32'h108);

      idle(); i_valid = 1; i_alu_op_CU = 1; i_rs_data = 32'h60; i_rt_data = 32'h1234;
      i_forwardB = 2'b10; i_aluResult_WB = 32'h60; i_rt_from_ID = 5'd9;
      step();
      chk("sub_res", o_alu_result, 32'd0);
      chk("sub_zero", {31'd0, o_alu_condition_zero}, 32'd1);
      chk("sub_dst", {27'd0, o_write_reg}, 32'd9);

      for (int i = 0; i < 40; i++) begin
         idle();
         i_valid = ($urandom_range(0, 7) != 0);
         i_alu_op_CU = 4'($urandom_range(0, 15));
         i_md_op_CU = $urandom_range(0, 1) ? 3'd7 : 3'd0;
         i_alu_src_CU = 1'($urandom_range(0, 1));
         i_reg_dst_CU = 1'($urandom_range(0, 1));
         i_jal_sel_CU = ($urandom_range(0, 7) == 0);
         i_rs_data = $urandom(); i_rt_data = $urandom();
         i_inst_sign_extended = $urandom(); i_shamt = 5'($urandom_range(0, 31));
         i_pc_plus8 = $urandom(); i_rd_from_ID = 5'($urandom_range(0, 31));
         i_rt_from_ID = 5'($urandom_range(0, 31));
         i_aluResult_MEM = $urandom(); i_aluResult_WB = $urandom();
         i_forwardA = 2'($urandom_range(0, 3)); i_forwardB = 2'($urandom_range(0, 3));
         if (i % 10 == 3) i_rt_data = i_rs_data;
         a = fwd_ref(i_forwardA, i_rs_data, i_aluResult_MEM, i_aluResult_WB);
         breg = fwd_ref(i_forwardB, i_rt_data, i_aluResult_MEM, i_aluResult_WB);
         b = i_alu_src_CU ? i_inst_sign_extended : breg;
         exp_res = i_jal_sel_CU ? i_pc_plus8 : alu_ref(i_alu_op_CU, a, b, i_inst_sign_extended, i_shamt);
         exp_dst = i_jal_sel_CU ? 5'd31 : (i_reg_dst_CU ? i_rd_from_ID : i_rt_from_ID);
         if (i_valid) begin
            step();
            chk("rnd_res", o_alu_result, exp_res);
            chk("rnd_dst", {27'd0, o_write_reg}, {27'd0, exp_dst});
            chk("rnd_store", o_store_data, breg);
            chk("rnd_zero", {31'd0, o_alu_condition_zero}, {31'd0, exp_res == 32'd0});
            chk("rnd_valid", {31'd0, o_valid}, 32'd1);
         end else begin
            step();
            chk("rnd_bubble", {o_alu_result[26:0], o_write_reg}, 32'd0);
            chk("rnd_bubble_valid", {31'd0, o_valid}, 32'd0);
         end
      end

      md_issue(3'd1, 32'hFFFF_FFFD, 32'd5);
      step();
      chk("mult_busy", {31'd0, o_md_busy}, 32'd1);
      idle(); i_valid = 1; i_md_op_CU = 3'd6; i_reg_dst_CU = 1; i_rd_from_ID = 5'd5;
      wait_stall(n);
      chk("mflo_stall_cycles", 32'(n), 32'd32);
      chk("stall_bubble_valid", {31'd0, o_valid}, 32'd0);
      step();
      chk("mflo_res", o_alu_result, 32'hFFFF_FFF1);
      chk("mflo_dst", {27'd0, o_write_reg}, 32'd5);
      i_md_op_CU = 3'd5;
      step();
      chk("mfhi_res", o_alu_result, 32'hFFFF_FFFF);

      md_check("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
      md_check("divu_zero", 3'd4, 32'h10, 32'd0);
      md_check("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      md_check("div_zero_s", 3'd3, 32'hFFFF_FF00, 32'd0);
      for (int i = 0; i < 6; i++) begin
         op = 3'($urandom_range(1, 4));
         a = $urandom();
         b = (i == 2) ? 32'd0 : (i == 4) ? 32'hFFFF_FFFF : $urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : $urandom();
         md_check("md_rnd", op, a, b);
      end

      md_issue(3'd1, 32'd7, 32'd9);
      step();
      idle(); i_valid = 1; i_alu_op_CU = 3; i_md_op_CU = 3'd7; i_rs_data = 32'hF0; i_rt_data = 32'h0F;
      i_reg_dst_CU = 1; i_rd_from_ID = 5'd4;
      #1 chk("or_no_stall", {31'd0, o_stall}, 32'd0);
      step();
      chk("or_res", o_alu_result, 32'hFF);
      chk("or_dst", {27'd0, o_write_reg}, 32'd4);
      chk("or_busy", {31'd0, o_md_busy}, 32'd1);
      md_issue(3'd2, 32'hFFFF_0001, 32'h0001_0003);
      #1 chk("mult2_stalled", {31'd0, o_stall}, 32'd1);
      wait_stall(n);
      chk("mult2_stall_cycles", 32'(n), 32'd31);
      step();
      chk("mult2_start_busy", {31'd0, o_md_busy}, 32'd1);
      chk("mult2_start_valid", {31'd0, o_valid}, 32'd1);
      idle();
      wait_busy(n);
      chk("mult2_busy_cycles", 32'(n), 32'd32);
      md_ref(3'd2, 32'hFFFF_0001, 32'h0001_0003, hi, lo);
      read_hilo("mult2", hi, lo);

      md_issue(3'd3, 32'd100, 32'd7);
      step();
      idle();
      repeat (22) step();
      chk("mid_div_busy", {31'd0, o_md_busy}, 32'd1);
      i_rst_n = 0;
      #1;
      chk("arst_busy", {31'd0, o_md_busy}, 32'd0);
      chk("arst_res", o_alu_result, 32'd0);
      chk("arst_outs", {o_store_data[26:0], o_write_reg}, 32'd0);
      chk("arst_flags", {29'd0, o_alu_condition_zero, o_valid, o_stall}, 32'd0);
      #2 i_rst_n = 1;
      read_hilo("post_rst", 32'd0, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised successor to the combinational EX stage.
- Contains the forwarding muxes, ALU, destination-register select and JAL link path.
- Adds a registered EX/MEM output boundary and an iterative multiply/divide unit with architectural HI/LO registers.
- Sits between the ID/EX register and the MEM stage; drives a stall back to the hazard unit while a HI/LO-dependent instruction must wait.

Parameters:
- NB_REG, 32, datapath width.
- NB_ADDR, 5, register-address width; the link register is 2^NB_ADDR-1.
- ALU_OP, 4, ALU opcode width.
- NB_MD_OP, 3, mult/div opcode width.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  an instruction is presented from ID/EX.
- i_alu_src_CU  in  1  1 selects immediate as ALU operand B.
- i_reg_dst_CU  in  1  1 selects rd, 0 selects rt as destination.
- i_jal_sel_CU  in  1  link: destination 2^NB_ADDR-1, result i_pc_plus8.
- i_alu_op_CU  in  ALU_OP  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI; others give 0.
- i_md_op_CU  in  NB_MD_OP  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO; 7 is treated as 0.
- i_rs_data, i_rt_data  in  NB_REG  register-file operands.
- i_inst_sign_extended  in  NB_REG  immediate.
- i_shamt  in  $clog2(NB_REG)  shift amount.
- i_pc_plus8  in  NB_REG  link address.
- i_rd_from_ID, i_rt_from_ID  in  NB_ADDR  destination candidates.
- i_aluResult_MEM, i_aluResult_WB  in  NB_REG  forwarded values.
- i_forwardA, i_forwardB  in  2  00 register, 01 MEM, 10 WB, 11 register.
- o_alu_result  out  NB_REG  registered result.
- o_write_reg  out  NB_ADDR  registered destination.
- o_store_data  out  NB_REG  registered forwarded rt.
- o_alu_condition_zero  out  1  registered (result==0).
- o_valid  out  1  registered instruction valid.
- o_stall  out  1  combinational; the ID/EX instruction must be held.
- o_md_busy  out  1  mult/div iteration in progress.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; HI=LO=0; busy=0; iteration counter 0. A reset during an iteration aborts it, and HI/LO stay 0.
- Operand selection:
  - A = fwd(i_forwardA, rs).
  - B_reg = fwd(i_forwardB, rt).
  - B = i_alu_src_CU ? immediate : B_reg.
  - o_store_data = B_reg.
- ALU latency is 1 cycle: a result computed from the inputs at edge N appears on the outputs after edge N.
- Shifts use B shifted by i_shamt. LUI = immediate<<16.
- SLT is signed and SLTU unsigned; result is 1/0 zero-extended. Arithmetic wraps modulo 2^NB_REG with no overflow trap.
- Destination: jal ? all-ones : (reg_dst ? rd : rt). With jal, the result is i_pc_plus8 regardless of the ALU op.
- o_stall = i_valid & ((md_op in 1..6) & busy).
- While o_stall=1 the stage captures a bubble: o_valid=0, o_write_reg=0, o_alu_result=0, and the presented instruction is not consumed.
- Non-MD instructions are never stalled by a busy MD unit.
- MD start: an accepted MULT/MULTU/DIV/DIVU latches A and B_reg, sets busy, and loads the counter with NB_REG. The instruction itself retires as a bubble-equivalent (o_valid=1, o_write_reg=0, o_alu_result=0).
- Iteration: one bit per cycle (shift-add multiply, restoring divide on magnitudes). On the edge where the counter reaches 0, HI/LO are written and busy clears.
- Busy is high for exactly NB_REG cycles after the accepting edge.
- Signed operations: operands are converted to magnitudes and the signs fixed at the end.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Multiply results: HI = upper half, LO = lower half of the 2*NB_REG product.
- Divide results: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = A.
- Signed overflow (min / -1): LO = min, HI = 0.
- MFHI/MFLO, accepted when not busy: the result is HI/LO, with normal destination select.
- An MFHI/MFLO or a new MD op arriving while busy is stalled until the cycle after busy falls.
- i_valid=0: the stage captures a bubble, and the MD unit still iterates.

Test Plan:
- Reset, then ADD with rs=0x10, rt=0x20, forwardA=01, MEM=0x30, reg_dst=1, rd=1 → after 1 edge: o_alu_result=0x50, o_write_reg=1, o_alu_condition_zero=0.
- JAL with i_pc_plus8=0x00000108 → o_write_reg=31, o_alu_result=0x108. SUB 0x60-0x60 via forwardB=10, WB=0x60 → result 0, zero=1.
- MULT -3×5, then MFLO presented the next cycle → o_stall=1 for 32 cycles. MFLO then retires o_alu_result=0xFFFFFFF1; a following MFHI gives 0xFFFFFFFF.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x10/0 → LO=0xFFFFFFFF, HI=0x10. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- During a busy MULT, an OR 0xF0|0x0F issued → no stall, result 0xFF after 1 edge. A second MULT issued while busy → stalled until busy falls.
- Assert i_rst_n=0 mid-DIV (counter=10) → o_md_busy=0 and all outputs 0 immediately. A subsequent MFLO returns 0 with no stall.
